// File: rtl/if_id_buffer.sv
`default_nettype none
// if_id_buffer: circular FIFO between fetch and decode with flush/freeze control.
// Define IF_ID_BYPASS_EN to present an incoming pair on the outputs the same cycle when empty.
module if_id_buffer #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pcIn,
  input  logic [N-1:0] instructionIn,
  input  logic         validIn,
  input  logic         flush,
  input  logic         freeze,
  output logic [N-1:0] pcOut,
  output logic [N-1:0] instructionOut,
  output logic         validOut,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [N-1:0]  pc_mem_q  [DEPTH];
  logic [N-1:0]  ins_mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic stored_valid;
  logic bypass_take;
  logic push;
  logic pop;

  assign stored_valid = (count_q != '0);
  assign full         = (count_q == FULL_CNT);

`ifdef IF_ID_BYPASS_EN
  logic bypass;
  assign bypass      = !stored_valid && validIn && !flush && rst;
  // A bypassed pair consumed this cycle never touches storage.
  assign bypass_take = bypass && !freeze;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = validIn && !full && !flush && !bypass_take;
  assign pop  = stored_valid && !freeze && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset: outputs are masked whenever the head slot is invalid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= pcIn;
      ins_mem_q[wr_ptr_q] <= instructionIn;
    end
  end

  always_comb begin
    validOut       = stored_valid;
    pcOut          = stored_valid ? pc_mem_q[rd_ptr_q]  : '0;
    instructionOut = stored_valid ? ins_mem_q[rd_ptr_q] : '0;
`ifdef IF_ID_BYPASS_EN
    if (bypass) begin
      validOut       = 1'b1;
      pcOut          = pcIn;
      instructionOut = instructionIn;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// Randomized and directed bench for if_id_buffer (default build) against a queue model.
module tb_if_id_buffer;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] pcIn = '0;
  logic [N-1:0] instructionIn = '0;
  logic         validIn = 1'b0;
  logic         flush = 1'b0;
  logic         freeze = 1'b0;
  logic [N-1:0] pcOut;
  logic [N-1:0] instructionOut;
  logic         validOut;
  logic         full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] pc;
    logic [N-1:0] ins;
  } entry_t;
  entry_t model_q[$];

  if_id_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pcIn(pcIn), .instructionIn(instructionIn),
    .validIn(validIn), .flush(flush), .freeze(freeze), .pcOut(pcOut),
    .instructionOut(instructionOut), .validOut(validOut), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] exp_pc;
    logic [N-1:0] exp_ins;
    exp_pc  = (model_q.size() != 0) ? model_q[0].pc  : '0;
    exp_ins = (model_q.size() != 0) ? model_q[0].ins : '0;
    check({tag, ".valid"}, 64'(validOut), 64'(model_q.size() != 0));
    check({tag, ".full"},  64'(full),     64'(model_q.size() == DEPTH));
    check({tag, ".pc"},    64'(pcOut),    64'(exp_pc));
    check({tag, ".ins"},   64'(instructionOut), 64'(exp_ins));
  endtask

  // One clock: model follows the rules with the inputs present at the edge.
  task automatic step(input string tag);
    bit do_pop, do_push;
    @(posedge clk);
    if (flush) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && !freeze;
      do_push = validIn && (model_q.size() < DEPTH);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back('{pcIn, instructionIn});
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [N-1:0] pc, input logic [N-1:0] ins,
                       input logic fr, input logic fl);
    validIn = v; pcIn = pc; instructionIn = ins; freeze = fr; flush = fl;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", 64'(validOut), 64'd0);
    check("reset.full",  64'(full),     64'd0);
    check("reset.pc",    64'(pcOut),    64'd0);
    @(negedge clk) rst = 1'b1;

    // Single push, visible next cycle, consumed the cycle after.
    drive(1'b1, 32'h4, 32'hE3A01005, 1'b0, 1'b0);
    step("single_push");
    check("single.pc", 64'(pcOut), 64'h4);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step("single_pop");
    check("single.gone", 64'(validOut), 64'd0);

    // Frozen fill past capacity, then drain in order.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(4 * (i + 1)), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
      step("fill");
      if (i == 3) check("fill.full4", 64'(full), 64'd1);
    end
    check("fill.head", 64'(pcOut), 64'h4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      step("drain");
    end

    // Flush with 3 buffered and an incoming pair.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h5A5A_0000 + 32'(i), 1'b1, 1'b0);
      step("preflush");
    end
    drive(1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1);
    step("flush");
    check("flush.valid", 64'(validOut), 64'd0);
    drive(1'b1, 32'h200, 32'h1234_5678, 1'b1, 1'b0);
    step("postflush");
    check("postflush.pc", 64'(pcOut), 64'h200);

    // Drain, then 10 continuous push+pop cycles to wrap pointers.
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step("drain2");
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0);
      step("stream");
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step("stream_end");

    // Asynchronous reset mid-cycle with 2 entries held.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 32'h7777_0000 + 32'(i), 1'b1, 1'b0);
      step("prereset");
    end
    #2 rst = 1'b0;
    #1;
    check("areset.valid", 64'(validOut), 64'd0);
    check("areset.pc",    64'(pcOut),    64'd0);
    check("areset.full",  64'(full),     64'd0);
    model_q.delete();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    step("after_reset");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
